// File: rtl/reorder_buffer_pkg.sv
// Shared constants and helpers for the 16-entry reorder buffer.
// Tag and destination encodings, including the "no entry" / "no register" values.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;
    localparam int ROBENTRY = 5;

    localparam logic [ROBENTRY-1:0] ENTRY_NULL = 5'b10000;
    localparam logic [5:0]          NULL_RD    = 6'b100000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [3:0]          rob_ptr_t;
    typedef logic [ROBENTRY-1:0] rob_tag_t;

    function automatic rob_ptr_t ptr_next(input rob_ptr_t p);
        return p + 4'd1;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order commit of up to one entry per cycle, flush on branch mispredict.
// Define ROB_QUERY_EN to add two combinational operand query ports (q1_*, q2_*).
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        issue_valid,
    input  logic [5:0]  issue_rd,
    input  logic        issue_is_br,
    input  logic        issue_pred,
    input  logic [31:0] issue_pc,
    output logic [4:0]  rob_new_entry,
    output logic        issue_sgn,
    output logic        rob_full,
    input  logic        cdb_valid,
    input  logic [4:0]  cdb_entry,
    input  logic [31:0] cdb_result,
    input  logic        cdb_taken,
    input  logic [31:0] cdb_target,
    output logic        commit_sgn,
    output logic [4:0]  rob_entry,
    output logic [5:0]  rob_des,
    output logic [31:0] rob_result,
    output logic        flush_sgn,
    output logic [31:0] flush_pc
`ifdef ROB_QUERY_EN
    ,
    input  logic [4:0]  q1_entry,
    input  logic [4:0]  q2_entry,
    output logic        q1_ready,
    output logic        q2_ready,
    output logic [31:0] q1_value,
    output logic [31:0] q2_value
`endif
);

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_is_br;
    logic [ROB_SIZE-1:0] r_pred;
    logic [ROB_SIZE-1:0] r_taken;
    logic [5:0]          r_rd     [ROB_SIZE];
    logic [31:0]         r_pc     [ROB_SIZE];
    logic [31:0]         r_result [ROB_SIZE];
    logic [31:0]         r_target [ROB_SIZE];

    rob_ptr_t    r_head;
    rob_ptr_t    r_tail;
    logic [4:0]  r_count;

    logic        r_commit_sgn;
    logic        r_flush_sgn;
    rob_tag_t    r_rob_entry;
    logic [5:0]  r_rob_des;
    logic [31:0] r_rob_result;
    logic [31:0] r_flush_pc;

    logic        w_full;
    logic        w_commit;
    logic        w_flush_pending;
    logic        w_issue;
    logic        w_cdb_wr;
    rob_ptr_t    w_cdb_idx;
    logic [4:0]  w_count_next;

    assign w_cdb_idx = cdb_entry[3:0];
    assign w_full    = (r_count == 5'(ROB_SIZE));

    // Commit reads only the registered ready bit, so a CDB write lands one cycle before its commit.
    assign w_commit        = rdy && r_busy[r_head] && r_ready[r_head];
    assign w_flush_pending = w_commit && r_is_br[r_head] && (r_taken[r_head] != r_pred[r_head]);
    assign w_issue         = issue_valid && !w_full && rdy && !w_flush_pending;
    assign w_cdb_wr        = rdy && cdb_valid && !cdb_entry[4] && r_busy[w_cdb_idx] && !w_flush_pending;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_count_next = r_count;
        case ({w_issue, w_commit})
            2'b10:   w_count_next = r_count + 5'd1;
            2'b01:   w_count_next = r_count - 5'd1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; a later <= to the same bit in one block
    // overrides an earlier one, which is how the one-cycle pulse defaults and the commit clear work.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_commit_sgn <= FALSE;
            r_flush_sgn  <= FALSE;
            r_rob_entry  <= ENTRY_NULL;
            r_rob_des    <= NULL_RD;
            r_rob_result <= '0;
            r_flush_pc   <= '0;
        end else begin
            r_commit_sgn <= FALSE;
            r_flush_sgn  <= FALSE;
            if (w_commit) begin
                r_commit_sgn <= TRUE;
                r_rob_entry  <= {1'b0, r_head};
                r_rob_des    <= r_is_br[r_head] ? NULL_RD : r_rd[r_head];
                r_rob_result <= r_result[r_head];
            end
            if (w_flush_pending) begin
                r_flush_sgn <= TRUE;
                r_flush_pc  <= r_taken[r_head] ? r_target[r_head] : r_pc[r_head] + 32'd4;
                r_busy      <= '0;
                r_ready     <= '0;
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
            end else begin
                if (w_issue) begin
                    r_busy[r_tail]  <= TRUE;
                    r_ready[r_tail] <= FALSE;
                    r_tail          <= ptr_next(r_tail);
                end
                if (w_cdb_wr) begin
                    r_ready[w_cdb_idx] <= TRUE;
                end
                if (w_commit) begin
                    r_busy[r_head]  <= FALSE;
                    r_ready[r_head] <= FALSE;
                    r_head          <= ptr_next(r_head);
                end
                r_count <= w_count_next;
            end
        end
    end

    // NOTE: payload arrays carry no reset; busy/ready gate every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd[r_tail]    <= issue_rd;
            r_is_br[r_tail] <= issue_is_br;
            r_pred[r_tail]  <= issue_pred;
            r_pc[r_tail]    <= issue_pc;
        end
        if (w_cdb_wr) begin
            r_result[w_cdb_idx] <= cdb_result;
            r_taken[w_cdb_idx]  <= cdb_taken;
            r_target[w_cdb_idx] <= cdb_target;
        end
    end

    assign rob_new_entry = {1'b0, r_tail};
    assign issue_sgn     = w_issue;
    assign rob_full      = w_full;
    assign commit_sgn    = r_commit_sgn;
    assign rob_entry     = r_rob_entry;
    assign rob_des       = r_rob_des;
    assign rob_result    = r_rob_result;
    assign flush_sgn     = r_flush_sgn;
    assign flush_pc      = r_flush_pc;

`ifdef ROB_QUERY_EN
    // Returns {ready, value}; a not-yet-ready busy entry picks up a matching CDB write this cycle.
    function automatic logic [32:0] query(input rob_tag_t tag);
        logic [32:0] res;
        rob_ptr_t    idx;
        res = '0;
        idx = tag[3:0];
        if (!tag[4] && r_busy[idx]) begin
            if (r_ready[idx]) begin
                res = {TRUE, r_result[idx]};
            end else if (cdb_valid && (cdb_entry == tag)) begin
                res = {TRUE, cdb_result};
            end
        end
        return res;
    endfunction

    always_comb begin
        {q1_ready, q1_value} = query(q1_entry);
        {q2_ready, q2_value} = query(q2_entry);
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized run
// against a queue-based model of the in-order commit behaviour.
module tb_reorder_buffer;

    localparam logic [4:0] ENTRY_NULL = 5'b10000;
    localparam logic [5:0] NULL_RD    = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic [5:0]  issue_rd;
    logic        issue_is_br;
    logic        issue_pred;
    logic [31:0] issue_pc;
    logic [4:0]  rob_new_entry;
    logic        issue_sgn;
    logic        rob_full;
    logic        cdb_valid;
    logic [4:0]  cdb_entry;
    logic [31:0] cdb_result;
    logic        cdb_taken;
    logic [31:0] cdb_target;
    logic        commit_sgn;
    logic [4:0]  rob_entry;
    logic [5:0]  rob_des;
    logic [31:0] rob_result;
    logic        flush_sgn;
    logic [31:0] flush_pc;
`ifdef ROB_QUERY_EN
    logic [4:0]  q1_entry;
    logic [4:0]  q2_entry;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_value;
    logic [31:0] q2_value;
`endif

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_is_br   (issue_is_br),
        .issue_pred    (issue_pred),
        .issue_pc      (issue_pc),
        .rob_new_entry (rob_new_entry),
        .issue_sgn     (issue_sgn),
        .rob_full      (rob_full),
        .cdb_valid     (cdb_valid),
        .cdb_entry     (cdb_entry),
        .cdb_result    (cdb_result),
        .cdb_taken     (cdb_taken),
        .cdb_target    (cdb_target),
        .commit_sgn    (commit_sgn),
        .rob_entry     (rob_entry),
        .rob_des       (rob_des),
        .rob_result    (rob_result),
        .flush_sgn     (flush_sgn),
        .flush_pc      (flush_pc)
`ifdef ROB_QUERY_EN
        ,
        .q1_entry      (q1_entry),
        .q2_entry      (q2_entry),
        .q1_ready      (q1_ready),
        .q2_ready      (q2_ready),
        .q1_value      (q1_value),
        .q2_value      (q2_value)
`endif
    );

    typedef struct {
        logic [3:0]  tag;
        logic [5:0]  rd;
        logic        is_br;
        logic        pred;
        logic [31:0] pc;
        logic        ready;
        logic [31:0] result;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_is_br = 1'b0;
        issue_pred  = 1'b0;
        issue_pc    = '0;
        cdb_valid   = 1'b0;
        cdb_entry   = '0;
        cdb_result  = '0;
        cdb_taken   = 1'b0;
        cdb_target  = '0;
`ifdef ROB_QUERY_EN
        q1_entry    = ENTRY_NULL;
        q2_entry    = ENTRY_NULL;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic drv_issue(input logic [5:0] rd, input logic br, input logic pr, input logic [31:0] pc);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_is_br = br;
        issue_pred  = pr;
        issue_pc    = pc;
    endtask

    task automatic drv_cdb(input logic [4:0] ent, input logic [31:0] res, input logic tk, input logic [31:0] tgt);
        cdb_valid  = 1'b1;
        cdb_entry  = ent;
        cdb_result = res;
        cdb_taken  = tk;
        cdb_target = tgt;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({commit_sgn, flush_sgn, rob_entry, rob_des, rob_result, flush_pc} !== {2'b00, ENTRY_NULL, NULL_RD, 32'h0, 32'h0})
            $display("FAIL reset_outputs got %h exp %h", {commit_sgn, flush_sgn, rob_entry, rob_des, rob_result, flush_pc},
                     {2'b00, ENTRY_NULL, NULL_RD, 32'h0, 32'h0});
        else n_pass++;
        #1;
        n_checks++;
        if ({rob_full, rob_new_entry, issue_sgn, dut.r_count} !== {1'b0, 5'd0, 1'b0, 5'd0})
            $display("FAIL reset_state got %h exp %h", {rob_full, rob_new_entry, issue_sgn, dut.r_count}, {1'b0, 5'd0, 1'b0, 5'd0});
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        drv_issue(6'd5, 1'b0, 1'b0, 32'h40);
        #1;
        n_checks++;
        if ({rob_new_entry, issue_sgn} !== {5'd0, 1'b1})
            $display("FAIL basic_issue got %h exp %h", {rob_new_entry, issue_sgn}, {5'd0, 1'b1});
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (dut.r_count !== 5'd1) $display("FAIL basic_count got %0d exp 1", dut.r_count);
        else n_pass++;
        drv_cdb(5'd0, 32'h1234, 1'b0, 32'h0);
        tick();
        idle_inputs();
        n_checks++;
        if (commit_sgn !== 1'b0) $display("FAIL basic_cdb_latency got %b exp 0", commit_sgn);
        else n_pass++;
        tick();
        n_checks++;
        if ({commit_sgn, rob_entry, rob_des, rob_result} !== {1'b1, 5'd0, 6'd5, 32'h1234})
            $display("FAIL basic_commit got %h exp %h", {commit_sgn, rob_entry, rob_des, rob_result}, {1'b1, 5'd0, 6'd5, 32'h1234});
        else n_pass++;
        tick();
        n_checks++;
        if ({commit_sgn, dut.r_count} !== {1'b0, 5'd0})
            $display("FAIL basic_after_commit got %h exp %h", {commit_sgn, dut.r_count}, {1'b0, 5'd0});
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drv_issue(6'(i), 1'b0, 1'b0, 32'(i * 4));
            tick();
        end
        idle_inputs();
        drv_issue(6'd40, 1'b0, 1'b0, 32'h400);
        drv_cdb(5'd0, 32'hF0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if ({rob_full, issue_sgn, rob_new_entry} !== {1'b1, 1'b0, 5'd0})
            $display("FAIL full_refuse got %h exp %h", {rob_full, issue_sgn, rob_new_entry}, {1'b1, 1'b0, 5'd0});
        else n_pass++;
        tick();
        cdb_valid = 1'b0;
        #1;
        n_checks++;
        if (issue_sgn !== 1'b0) $display("FAIL full_commit_no_free got %b exp 0", issue_sgn);
        else n_pass++;
        tick();
        n_checks++;
        if ({commit_sgn, rob_entry, rob_des, rob_result} !== {1'b1, 5'd0, 6'd0, 32'hF0})
            $display("FAIL full_commit got %h exp %h", {commit_sgn, rob_entry, rob_des, rob_result}, {1'b1, 5'd0, 6'd0, 32'hF0});
        else n_pass++;
        #1;
        n_checks++;
        if ({rob_full, rob_new_entry, issue_sgn} !== {1'b0, 5'd0, 1'b1})
            $display("FAIL full_wrap_issue got %h exp %h", {rob_full, rob_new_entry, issue_sgn}, {1'b0, 5'd0, 1'b1});
        else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if ({dut.r_count, rob_full, rob_new_entry} !== {5'd16, 1'b1, 5'd1})
            $display("FAIL full_refill got %h exp %h", {dut.r_count, rob_full, rob_new_entry}, {5'd16, 1'b1, 5'd1});
        else n_pass++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv_issue(6'(10 + i), 1'b0, 1'b0, 32'h0);
            tick();
        end
        idle_inputs();
        for (int i = 2; i >= 0; i--) begin
            drv_cdb(5'(i), 32'hA0 + 32'(i), 1'b0, 32'h0);
            tick();
            idle_inputs();
            n_checks++;
            if (commit_sgn !== 1'b0) $display("FAIL ooo_early_commit_%0d got %b exp 0", i, commit_sgn);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({commit_sgn, rob_entry, rob_des, rob_result} !== {1'b1, 5'(i), 6'(10 + i), 32'hA0 + 32'(i)})
                $display("FAIL ooo_commit_%0d got %h exp %h", i, {commit_sgn, rob_entry, rob_des, rob_result},
                         {1'b1, 5'(i), 6'(10 + i), 32'hA0 + 32'(i)});
            else n_pass++;
        end
    endtask

    task automatic test_mispredict();
        logic        pred_v  [2] = '{1'b0, 1'b1};
        logic        taken_v [2] = '{1'b1, 1'b0};
        logic [31:0] pc_v    [2] = '{32'h200, 32'h104};
        for (int c = 0; c < 2; c++) begin
            do_reset();
            drv_issue(6'd3, 1'b1, pred_v[c], 32'h100);
            tick();
            drv_issue(6'd4, 1'b0, 1'b0, 32'h108);
            tick();
            idle_inputs();
            drv_cdb(5'd0, 32'h55, taken_v[c], 32'h200);
            tick();
            idle_inputs();
            drv_issue(6'd9, 1'b0, 1'b0, 32'h300);
            drv_cdb(5'd1, 32'h66, 1'b0, 32'h0);
            #1;
            n_checks++;
            if (issue_sgn !== 1'b0) $display("FAIL mis_issue_block_%0d got %b exp 0", c, issue_sgn);
            else n_pass++;
            tick();
            idle_inputs();
            #1;
            n_checks++;
            if ({commit_sgn, flush_sgn, rob_entry, rob_des, flush_pc, dut.r_count, rob_new_entry} !==
                {1'b1, 1'b1, 5'd0, NULL_RD, pc_v[c], 5'd0, 5'd0})
                $display("FAIL mis_flush_%0d got %h exp %h", c,
                         {commit_sgn, flush_sgn, rob_entry, rob_des, flush_pc, dut.r_count, rob_new_entry},
                         {1'b1, 1'b1, 5'd0, NULL_RD, pc_v[c], 5'd0, 5'd0});
            else n_pass++;
            tick();
            n_checks++;
            if ({commit_sgn, flush_sgn, dut.r_count} !== {1'b0, 1'b0, 5'd0})
                $display("FAIL mis_after_%0d got %h exp %h", c, {commit_sgn, flush_sgn, dut.r_count}, {1'b0, 1'b0, 5'd0});
            else n_pass++;
        end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        drv_issue(6'd7, 1'b0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        drv_cdb(5'd0, 32'h77, 1'b0, 32'h0);
        tick();
        idle_inputs();
        rdy = 1'b0;
        drv_issue(6'd8, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (issue_sgn !== 1'b0) $display("FAIL rdy_issue_%0d got %b exp 0", i, issue_sgn);
            else n_pass++;
            tick();
            n_checks++;
            if ({commit_sgn, flush_sgn, dut.r_count, rob_new_entry} !== {1'b0, 1'b0, 5'd1, 5'd1})
                $display("FAIL rdy_hold_%0d got %h exp %h", i, {commit_sgn, flush_sgn, dut.r_count, rob_new_entry},
                         {1'b0, 1'b0, 5'd1, 5'd1});
            else n_pass++;
        end
        rdy = 1'b1;
        idle_inputs();
        tick();
        n_checks++;
        if ({commit_sgn, rob_entry, rob_des, rob_result} !== {1'b1, 5'd0, 6'd7, 32'h77})
            $display("FAIL rdy_resume got %h exp %h", {commit_sgn, rob_entry, rob_des, rob_result}, {1'b1, 5'd0, 6'd7, 32'h77});
        else n_pass++;
        drv_issue(6'd8, 1'b0, 1'b0, 32'h0);
        tick();
        drv_issue(6'd9, 1'b0, 1'b0, 32'h0);
        drv_cdb(5'd1, 32'h88, 1'b0, 32'h0);
        tick();
        idle_inputs();
        rst = 1'b1;
        rdy = 1'b0;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        n_checks++;
        if ({commit_sgn, flush_sgn, rob_entry, rob_des, rob_result, flush_pc, dut.r_count, rob_new_entry} !==
            {2'b00, ENTRY_NULL, NULL_RD, 32'h0, 32'h0, 5'd0, 5'd0})
            $display("FAIL rst_midstream got %h exp %h",
                     {commit_sgn, flush_sgn, rob_entry, rob_des, rob_result, flush_pc, dut.r_count, rob_new_entry},
                     {2'b00, ENTRY_NULL, NULL_RD, 32'h0, 32'h0, 5'd0, 5'd0});
        else n_pass++;
        tick();
        n_checks++;
        if (commit_sgn !== 1'b0) $display("FAIL rst_no_commit got %b exp 0", commit_sgn);
        else n_pass++;
    endtask

`ifdef ROB_QUERY_EN
    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv_issue(6'(i), 1'b0, 1'b0, 32'h0);
            tick();
        end
        idle_inputs();
        q1_entry = 5'd3;
        q2_entry = 5'd2;
        drv_cdb(5'd3, 32'd7, 1'b0, 32'h0);
        #1;
        n_checks++;
        if ({q1_ready, q1_value, q2_ready, q2_value} !== {1'b1, 32'd7, 1'b0, 32'd0})
            $display("FAIL query_forward got %h exp %h", {q1_ready, q1_value, q2_ready, q2_value}, {1'b1, 32'd7, 1'b0, 32'd0});
        else n_pass++;
        tick();
        cdb_valid = 1'b0;
        q2_entry  = ENTRY_NULL;
        #1;
        n_checks++;
        if ({q1_ready, q1_value, q2_ready, q2_value} !== {1'b1, 32'd7, 1'b0, 32'd0})
            $display("FAIL query_stored got %h exp %h", {q1_ready, q1_value, q2_ready, q2_value}, {1'b1, 32'd7, 1'b0, 32'd0});
        else n_pass++;
        q2_entry = 5'd9;
        #1;
        n_checks++;
        if ({q2_ready, q2_value} !== {1'b0, 32'd0})
            $display("FAIL query_not_busy got %h exp %h", {q2_ready, q2_value}, {1'b0, 32'd0});
        else n_pass++;
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        ent_t        q[$];
        ent_t        h;
        ent_t        e;
        logic [3:0]  next_tag;
        logic        head_ok;
        logic        mis;
        logic        exp_issue;
        logic [4:0]  exp_entry;
        logic [5:0]  exp_des;
        logic [31:0] exp_res;
        logic [31:0] exp_fpc;
        do_reset();
        next_tag  = '0;
        exp_entry = ENTRY_NULL;
        exp_des   = NULL_RD;
        exp_res   = '0;
        exp_fpc   = '0;
        h         = '{default: '0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy         = ($urandom_range(0, 9) != 0);
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_rd    = 6'($urandom_range(0, 31));
            issue_is_br = ($urandom_range(0, 3) == 0);
            issue_pred  = 1'($urandom);
            issue_pc    = $urandom & ~32'h3;
            cdb_valid   = 1'($urandom);
            if (q.size() > 0 && $urandom_range(0, 4) != 0)
                cdb_entry = {1'b0, q[$urandom_range(0, q.size() - 1)].tag};
            else
                cdb_entry = 5'($urandom_range(0, 31));
            cdb_result = $urandom;
            cdb_taken  = 1'($urandom);
            cdb_target = $urandom & ~32'h3;

            head_ok = rdy && (q.size() > 0) && q[0].ready;
            if (head_ok) h = q[0];
            mis       = head_ok && h.is_br && (h.taken != h.pred);
            exp_issue = issue_valid && (q.size() < 16) && rdy && !mis;
            #1;
            n_checks++;
            if ({rob_full, rob_new_entry, issue_sgn} !== {(q.size() == 16), {1'b0, next_tag}, exp_issue})
                $display("FAIL rand_comb_%0d got %h exp %h", cyc, {rob_full, rob_new_entry, issue_sgn},
                         {(q.size() == 16), {1'b0, next_tag}, exp_issue});
            else n_pass++;

            if (rdy && cdb_valid && !mis && !cdb_entry[4]) begin
                foreach (q[k]) begin
                    if (q[k].tag == cdb_entry[3:0]) begin
                        q[k].ready  = 1'b1;
                        q[k].result = cdb_result;
                        q[k].taken  = cdb_taken;
                        q[k].target = cdb_target;
                    end
                end
            end
            if (head_ok) begin
                void'(q.pop_front());
                exp_entry = {1'b0, h.tag};
                exp_des   = h.is_br ? NULL_RD : h.rd;
                exp_res   = h.result;
                if (mis) begin
                    exp_fpc  = h.taken ? h.target : h.pc + 32'd4;
                    q.delete();
                    next_tag = '0;
                end
            end
            if (exp_issue) begin
                e = '{tag: next_tag, rd: issue_rd, is_br: issue_is_br, pred: issue_pred, pc: issue_pc,
                      ready: 1'b0, result: 32'h0, taken: 1'b0, target: 32'h0};
                q.push_back(e);
                next_tag = next_tag + 4'd1;
            end

            tick();
            n_checks++;
            if ({commit_sgn, flush_sgn, rob_entry, rob_des, rob_result, flush_pc, dut.r_count} !==
                {head_ok, mis, exp_entry, exp_des, exp_res, exp_fpc, 5'(q.size())})
                $display("FAIL rand_seq_%0d got %h exp %h", cyc,
                         {commit_sgn, flush_sgn, rob_entry, rob_des, rob_result, flush_pc, dut.r_count},
                         {head_ok, mis, exp_entry, exp_des, exp_res, exp_fpc, 5'(q.size())});
            else n_pass++;
        end
        rdy = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_rdy_hold();
`ifdef ROB_QUERY_EN
        test_query();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk in 1, rst in 1 (sync, active-high); rdy in 1, global pause when low.
REQ-002 SHALL have issue inputs: issue_valid in 1 (decoder request); issue_rd in 6 (destination, `NULL = none); issue_is_br in 1; issue_pred in 1 (predicted taken); issue_pc in 32.
REQ-003 SHALL have issue outputs: rob_new_entry out 5 (tail tag, combinational); issue_sgn out 1 (issue accepted this cycle); rob_full out 1.
REQ-004 SHALL have result-bus inputs: cdb_valid in 1; cdb_entry in 5; cdb_result in 32; cdb_taken in 1; cdb_target in 32.
REQ-005 SHALL have commit outputs: commit_sgn out 1; rob_entry out 5; rob_des out 6; rob_result out 32.
REQ-006 SHALL have flush outputs: flush_sgn out 1; flush_pc out 32.
REQ-007 SHALL have query ports, present only under ROB_QUERY_EN: q1_entry in 5, q2_entry in 5, q1_ready out 1, q2_ready out 1, q1_value out 32, q2_value out 32.

Function
REQ-008 SHALL be a 16-entry circular buffer with head, tail and count (0..16) registers; tags 0..15, `ENTRY_NULL = 5'b10000.
REQ-009 SHALL drive rob_full = (count==16) and issue_sgn = issue_valid && !rob_full && rdy && !flush_pending, all combinational.
REQ-010 SHALL, on issue_sgn, write {busy=1, ready=0, rd, is_br, pred, pc} at tail; tail advances mod 16 next cycle.
REQ-011 SHALL, on cdb_valid with cdb_entry pointing to a busy entry, set ready=1 and latch result, taken and target; writes to non-busy or `ENTRY_NULL tags SHALL be ignored.
REQ-012 SHALL commit at most one entry per cycle: when head entry is busy and ready, register commit_sgn=1, rob_entry=head, rob_des=rd, rob_result=result for exactly one cycle, clear busy, and advance head.
REQ-013 SHALL, for a branch entry, drive rob_des=`NULL on commit.
REQ-014 SHALL, when a committing branch has taken != pred, also pulse flush_sgn for one cycle with flush_pc = taken ? target : pc+4; in the same edge all entries SHALL be cleared and head=tail=count=0.
REQ-015 SHALL refuse issue in the cycle a mispredict commits (flush_pending); a cdb write in that cycle SHALL be dropped.
REQ-016 SHALL, on simultaneous issue and commit, update count by net zero; a commit does not free space for a same-cycle issue when full.
REQ-017 SHALL, on cdb write to head in the same cycle, not commit it until the following cycle (one-cycle minimum CDB-to-commit latency).
REQ-018 SHALL, when rdy is low, hold all state; commit_sgn, flush_sgn and issue_sgn SHALL be 0.

Reset
REQ-019 SHALL, on rst, clear all busy/ready bits, zero head, tail and count, and drive commit_sgn=0, flush_sgn=0, rob_entry=`ENTRY_NULL, rob_des=`NULL, rob_result=0, flush_pc=0; rst overrides rdy.

Configuration
REQ-020 SHALL, with ROB_QUERY_EN defined, return ready/value for the queried busy entry combinationally, forwarding a same-cycle matching cdb write; an `ENTRY_NULL or non-busy tag SHALL return ready=0, value=0.
REQ-021 SHALL, with ROB_QUERY_EN undefined, omit the query ports and storage muxes entirely.

Structure
REQ-022 SHALL take `ROBENTRY, `ENTRY_NULL, `NULL, ROB_SIZE and TRUE/FALSE from defines.v; no sub-module is required; entry storage SHALL be per-field register arrays.

Verification
REQ-023 SHALL be verified by: reset then issue rd=5 -> rob_new_entry=0, next cycle count=1; cdb entry 0 result 0x1234 -> commit_sgn with rob_des=5 and rob_result=0x1234 one cycle later.
REQ-024 SHALL be verified by: 16 issues with no cdb -> rob_full=1, 17th issue_valid gives issue_sgn=0; one commit -> tail wraps to 0 and issue is accepted.
REQ-025 SHALL be verified by: out-of-order cdb to entries 2,1,0 -> commits in order 0,1,2 on consecutive cycles.
REQ-026 SHALL be verified by: branch at pc=0x100, pred=0, cdb taken=1 target=0x200 -> flush_sgn with flush_pc=0x200, count=0 next cycle; pred=1, taken=0 -> flush_pc=0x104.
REQ-027 SHALL be verified by: rdy low for 3 cycles with a ready head -> no commit, state unchanged; rst asserted mid-stream -> all outputs at reset values next cycle.
REQ-028 SHALL be verified, under ROB_QUERY_EN, by: q1_entry=3 with same-cycle cdb to entry 3 value 7 -> q1_ready=1, q1_value=7.
